wptr_full: RTL and testbench

Write-domain pointer and full-flag logic for the asynchronous display FIFO. It is the write-side counterpart of the read-pointer/empty block, which pops two entries per read. This block accepts one entry per write on `wclk` and keeps a binary write pointer. It publishes that pointer as Gray code and synchronises the read domain's Gray pointer into `wclk`. From the two pointers it derives full, almost-full, fill level and a sticky overflow error.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/ptr_sync.sv | 30 +++
 rtl/wptr_full.sv | 80 ++++++++
 tb/tb_wptr_full.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and pointer-code helpers for the asynchronous display FIFO.
// Used by both the write-side (wptr_full) and read-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
  localparam int DEPTH       = 2 ** FIFO_ADDR_W;

  typedef logic [FIFO_PTR_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b[FIFO_PTR_W-1] = g[FIFO_PTR_W-1];
    for (int unsigned i = 1; i < FIFO_PTR_W; i++) begin
      b[FIFO_PTR_W-1-i] = b[FIFO_PTR_W-i] ^ g[FIFO_PTR_W-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-bit flop chain for carrying a Gray pointer into another clock domain.
// Reused in both directions; all stages clear to zero on reset.
module ptr_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, Gray publish, read-pointer sync and full/level flags.
// The read side advances two entries per pop, so synchronised samples are filtered.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int WPTR_WIDTH  = 4,
  parameter int RPTR_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [RPTR_WIDTH-1:0] gray_rd_ptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [WPTR_WIDTH-1:0] wfill,
  output logic                  woverflow,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [WPTR_WIDTH-1:0] gray_wr_ptr
);

  localparam logic [WPTR_WIDTH-1:0] FULL_LVL  = WPTR_WIDTH'(DEPTH);
  localparam logic [WPTR_WIDTH-1:0] AFULL_LVL = WPTR_WIDTH'(DEPTH - 1);
  localparam logic [WPTR_WIDTH-1:0] PTR_ONE   = WPTR_WIDTH'(1);

  logic [WPTR_WIDTH-1:0] bn_wptr;
  logic [WPTR_WIDTH-1:0] bn_rptr_s;
  logic [RPTR_WIDTH-1:0] rp_sync;
  logic [WPTR_WIDTH-1:0] rp_bin;
  logic [WPTR_WIDTH-1:0] rd_adv;
  logic                  rp_accept;
  logic                  wen;

  ptr_sync #(
    .WIDTH       (RPTR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d      (gray_rd_ptr),
    .q      (rp_sync)
  );

  always_comb begin
    wfill        = bn_wptr - bn_rptr_s;
    wfull        = (wfill == FULL_LVL);
    walmost_full = (wfill >= AFULL_LVL);
    wen          = winc & ~wfull;
    rp_bin       = gray2bin(rp_sync);
    rd_adv       = rp_bin - bn_rptr_s;
    // Even Gray parity is the same as a zero binary LSB; a torn two-bit
    // transition shows up as an odd value or as a reader ahead of the writer.
    rp_accept    = ~rp_bin[0] & (rd_adv <= wfill);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      bn_wptr     <= '0;
      bn_rptr_s   <= '0;
      gray_wr_ptr <= '0;
      woverflow   <= 1'b0;
    end else begin
      if (wen) begin
        bn_wptr <= bn_wptr + PTR_ONE;
      end
      // Published one cycle behind bn_wptr so the written entry settles first.
      gray_wr_ptr <= bin2gray(bn_wptr);
      if (rp_accept) begin
        bn_rptr_s <= rp_bin;
      end
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end
    end
  end

  assign w_addr = bn_wptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_wptr_full.sv
// Randomised self-checking bench for wptr_full against a count-based reference model.
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [3:0] gray_rd_ptr = 4'd0;
  logic       wfull, walmost_full, woverflow;
  logic [3:0] wfill, gray_wr_ptr;
  logic [2:0] w_addr;

  int tests = 0;
  int fails = 0;

  // Reference model: pointers as plain integers mod 16, sync delay as a queue.
  int         m_w, m_rs, m_gw;
  bit         m_ovf;
  logic [3:0] hist[$];
  int         wr_total, rd_total;

  always #5 wclk = ~wclk;

  wptr_full #(
    .WPTR_WIDTH  (4),
    .RPTR_WIDTH  (4),
    .ADDR_WIDTH  (3),
    .SYNC_STAGES (2)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .gray_rd_ptr  (gray_rd_ptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wfill        (wfill),
    .woverflow    (woverflow),
    .w_addr       (w_addr),
    .gray_wr_ptr  (gray_wr_ptr)
  );

  function automatic int b2g(int b);
    return (b & 15) ^ ((b & 15) >> 1);
  endfunction

  // Inverse Gray by search: the binary value whose Gray code matches.
  function automatic int g2b(int g);
    for (int n = 0; n < 16; n++) begin
      if (b2g(n) == g) return n;
    end
    return 0;
  endfunction

  function automatic int m_fill();
    return (m_w - m_rs) & 15;
  endfunction

  function automatic logic [13:0] m_exp();
    int f;
    f = m_fill();
    return {f == 8, f >= 7, 4'(f), m_ovf, 3'(m_w & 7), 4'(m_gw)};
  endfunction

  task automatic tick(input bit inc, input logic [3:0] g);
    int f, rp, nrs;
    f   = m_fill();
    rp  = g2b(int'(hist[0]));
    nrs = m_rs;
    if (inc && f == 8) m_ovf = 1'b1;
    m_gw = b2g(m_w);
    if ((rp % 2) == 0 && ((rp - m_rs) & 15) <= f) nrs = rp;
    if (inc && f != 8) begin
      m_w = (m_w + 1) & 15;
      wr_total++;
    end
    m_rs = nrs;
    hist.push_back(g);
    void'(hist.pop_front());
    winc = inc;
    gray_rd_ptr = g;
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    winc = 1'b0;
    gray_rd_ptr = 4'd0;
    wrst_n = 1'b0;
    #1;
    m_w = 0; m_rs = 0; m_gw = 0; m_ovf = 1'b0;
    hist = '{4'd0, 4'd0};
    wr_total = 0; rd_total = 0;
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] act;
    do_reset();
    act = {wfull, walmost_full, wfill, woverflow, w_addr, gray_wr_ptr};
    tests++;
    if (act !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", act, 14'd0);
    end
  endtask

  task automatic test_fill();
    logic [13:0] act;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (w_addr !== 3'(i)) begin
        fails++;
        $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, w_addr, i);
      end
      tick(1'b1, 4'd0);
      act = {wfull, walmost_full, wfill, woverflow, w_addr, gray_wr_ptr};
      tests++;
      if (act !== m_exp()) begin
        fails++;
        $display("FAIL fill_state[%0d]: got %h expected %h", i, act, m_exp());
      end
    end
  endtask

  task automatic test_overflow();
    tick(1'b1, 4'd0);
    tests++;
    if ({wfill, w_addr, woverflow, wfull} !== {4'd8, 3'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL overflow_write: got fill=%0d addr=%0d ovf=%b full=%b expected 8 0 1 1",
               wfill, w_addr, woverflow, wfull);
    end
    repeat (3) tick(1'b0, 4'd0);
    tests++;
    if (woverflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: got %b expected 1", woverflow);
    end
    do_reset();
    tests++;
    if (woverflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_reset: got %b expected 0", woverflow);
    end
  endtask

  task automatic test_read_frees();
    do_reset();
    repeat (8) tick(1'b1, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 4'b0011);
      tests++;
      if (i < 3 && wfull !== 1'b1) begin
        fails++;
        $display("FAIL read_latency_early[%0d]: got full=%b expected 1", i, wfull);
      end else if (i == 3 && {wfull, wfill} !== {1'b0, 4'd6}) begin
        fails++;
        $display("FAIL read_frees: got full=%b fill=%0d expected 0 6", wfull, wfill);
      end
    end
    repeat (2) tick(1'b1, 4'b0011);
    tests++;
    if ({wfull, wfill} !== {1'b1, 4'd8}) begin
      fails++;
      $display("FAIL refill: got full=%b fill=%0d expected 1 8", wfull, wfill);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] act;
    logic [3:0]  prev_gw;
    logic [2:0]  prev_addr;
    bit          saw_wrap, inc;
    int          cyc;
    do_reset();
    prev_gw = gray_wr_ptr;
    prev_addr = w_addr;
    saw_wrap = 1'b0;
    cyc = 0;
    while (wr_total < 20 && cyc < 400) begin
      inc = ($urandom_range(0, 3) != 0) && (m_fill() != 8);
      if (wr_total - rd_total >= 2 && $urandom_range(0, 2) == 0) rd_total += 2;
      tick(inc, 4'(b2g(rd_total)));
      cyc++;
      act = {wfull, walmost_full, wfill, woverflow, w_addr, gray_wr_ptr};
      tests++;
      if (act !== m_exp()) begin
        fails++;
        $display("FAIL wrap_state[%0d]: got %h expected %h", cyc, act, m_exp());
      end
      tests++;
      if ($countones(gray_wr_ptr ^ prev_gw) > 1 || wfill > 4'd8 || woverflow !== 1'b0) begin
        fails++;
        $display("FAIL wrap_invariant[%0d]: got gray %b->%b fill=%0d ovf=%b expected 1-bit step fill<=8 ovf=0",
                 cyc, prev_gw, gray_wr_ptr, wfill, woverflow);
      end
      if (prev_addr == 3'd7 && w_addr == 3'd0) saw_wrap = 1'b1;
      prev_gw = gray_wr_ptr;
      prev_addr = w_addr;
    end
    tests++;
    if (wr_total < 20 || !saw_wrap) begin
      fails++;
      $display("FAIL wrap_progress: got writes=%0d wrap=%b expected 20 1", wr_total, saw_wrap);
    end
  endtask

  task automatic test_torn();
    do_reset();
    repeat (4) tick(1'b1, 4'd0);
    tests++;
    if (wfill !== 4'd4) begin
      fails++;
      $display("FAIL torn_setup: got fill=%0d expected 4", wfill);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b0001);
      tests++;
      if (wfill !== 4'(m_fill()) || wfill !== 4'd4) begin
        fails++;
        $display("FAIL torn_reject[%0d]: got fill=%0d expected 4", i, wfill);
      end
    end
    repeat (3) tick(1'b0, 4'b0110);
    tests++;
    if ({wfill, wfull, walmost_full} !== {4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL torn_accept: got fill=%0d full=%b afull=%b expected 0 0 0",
               wfill, wfull, walmost_full);
    end
  endtask

  task automatic test_random();
    logic [13:0] act;
    logic [3:0]  g;
    bit          inc;
    int          sel;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      inc = bit'($urandom_range(0, 1));
      if (wr_total - rd_total >= 2 && $urandom_range(0, 1) == 0) rd_total += 2;
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      g = 4'(b2g(rd_total + 1));
      else if (sel == 1) g = 4'(b2g(wr_total + 2));
      else               g = 4'(b2g(rd_total));
      tick(inc, g);
      act = {wfull, walmost_full, wfill, woverflow, w_addr, gray_wr_ptr};
      tests++;
      if (act !== m_exp()) begin
        fails++;
        $display("FAIL random_state[%0d]: got %h expected %h", c, act, m_exp());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) tick(1'b1, 4'd0);
    #2;
    wrst_n = 1'b0;
    #1;
    tests++;
    if ({w_addr, gray_wr_ptr, wfill} !== {3'd0, 4'd0, 4'd0}) begin
      fails++;
      $display("FAIL reset_mid: got addr=%0d gray=%b fill=%0d expected 0 0000 0",
               w_addr, gray_wr_ptr, wfill);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_frees();
    test_wrap();
    test_torn();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
